// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester data memory arbiter with 1-cycle read return
module data_mem_arbiter #(
    parameter int ADDR_SIZE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        range_err
);

    logic        prio;
    logic        pend_valid;
    logic        pend_owner;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        out_of_range;

    // prio only matters when both requesters contend
    assign grant0 = m0_req_valid & (~m1_req_valid | ~prio);
    assign grant1 = m1_req_valid & (~m0_req_valid | prio);
    assign xfer   = grant0 | grant1;

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        if (grant0) begin
            sel_we    = m0_req_we;
            sel_addr  = m0_req_addr;
            sel_wdata = m0_req_wdata;
        end else if (grant1) begin
            sel_we    = m1_req_we;
            sel_addr  = m1_req_addr;
            sel_wdata = m1_req_wdata;
        end
    end

    assign out_of_range = (sel_addr >> (ADDR_SIZE + 1)) != 32'd0;

    assign mem_write_enable = xfer & sel_we;
    assign mem_write_addr   = mem_write_enable ? sel_addr : 32'd0;
    assign mem_write_data   = mem_write_enable ? sel_wdata : 32'd0;
    assign mem_read_addr    = (xfer & ~sel_we) ? sel_addr : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= 1'b0;
            pend_valid <= 1'b0;
            pend_owner <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            if (xfer) begin
                prio <= grant0;
            end
            pend_valid <= xfer & ~sel_we;
            pend_owner <= grant1;
            if (xfer && out_of_range) begin
                range_err <= 1'b1;
            end
        end
    end

    // the memory returns data one cycle after the address, matching the pending tag
    assign m0_rsp_valid = pend_valid & ~pend_owner;
    assign m1_rsp_valid = pend_valid & pend_owner;
    assign m0_rsp_rdata = m0_rsp_valid ? mem_read_data : 32'd0;
    assign m1_rsp_rdata = m1_rsp_valid ? mem_read_data : 32'd0;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface

- REQ-001: The module SHALL have parameter ADDR_SIZE, default 7, giving the MSB index of the word address field (addr[ADDR_SIZE:2]) used by the attached data memory.
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: m0_req_valid  input  1  requester 0 has a request.
- REQ-005: m0_req_ready  output  1  requester 0 request accepted this cycle.
- REQ-006: m0_req_we  input  1  1 = write, 0 = read.
- REQ-007: m0_req_addr  input  32  byte address.
- REQ-008: m0_req_wdata  input  32  write data.
- REQ-009: m0_rsp_valid  output  1  read data valid for requester 0.
- REQ-010: m0_rsp_rdata  output  32  read data for requester 0.
- REQ-011: The m1_* ports SHALL be identical to REQ-004..REQ-010, for requester 1.
- REQ-012: mem_read_addr  output  32  memory read byte address.
- REQ-013: mem_read_data  input  32  memory read data, valid one cycle after the address is presented.
- REQ-014: mem_write_addr  output  32  memory write byte address.
- REQ-015: mem_write_data  output  32  memory write data.
- REQ-016: mem_write_enable  output  1  memory write strobe.
- REQ-017: range_err  output  1  sticky out-of-range flag.

Function

- REQ-018: Arbitration SHALL be combinational:
  - grant goes to the single valid requester;
  - if both are valid, grant goes to the requester selected by the registered priority bit prio (0 = m0, 1 = m1).
- REQ-019: mN_req_ready SHALL equal grantN; at most one ready SHALL be high per cycle; a transfer occurs when valid and ready are both high.
- REQ-020: After any transfer by mN, prio SHALL be set to the other requester on the next edge; with no transfer, prio SHALL hold.
- REQ-021: A granted write SHALL drive, in the same cycle:
  - mem_write_enable = 1;
  - mem_write_addr = req_addr;
  - mem_write_data = req_wdata.
- REQ-022: Without a granted write, mem_write_enable, mem_write_addr and mem_write_data SHALL all be 0.
- REQ-023: A granted read SHALL drive mem_read_addr = req_addr in the same cycle; otherwise mem_read_addr SHALL be 0.
- REQ-024: Each granted read SHALL register a pending tag (valid, owner).
- REQ-025: On the next cycle, the owner's rsp_valid SHALL be 1 and its rsp_rdata SHALL equal mem_read_data, giving a fixed read latency of 1 cycle after the transfer.
- REQ-026: A non-owner's rsp_rdata SHALL be 0, and a non-owner's rsp_valid SHALL be 0.
- REQ-027: Writes SHALL produce no response.
- REQ-028: Back-to-back reads, one per cycle from either requester, SHALL be sustained with no bubbles.
- REQ-029: A read transferred in the cycle after a write to the same word SHALL return the written data.
- REQ-030: addr[1:0] SHALL be forwarded unchanged; the memory ignores these bits, and the arbiter SHALL not flag them.
- REQ-031: On a transfer whose addr[31:ADDR_SIZE+1] is nonzero:
  - range_err SHALL set to 1 on the next edge and stay set until reset;
  - the access SHALL still be forwarded.
- REQ-032: Requesters SHALL hold valid, we, addr and wdata stable until ready; the arbiter SHALL not need to register them.

Reset

- REQ-033: While rst = 1, regardless of clk:
  - prio SHALL be 0;
  - the pending tag SHALL be cleared;
  - range_err SHALL be 0;
  - both rsp_valid SHALL be 0;
  - both rsp_rdata SHALL be 0.
- REQ-034: A read accepted in the cycle before rst asserts SHALL be dropped; no rsp_valid SHALL appear after reset releases.
- REQ-035: During reset, req_ready and mem_* outputs SHALL follow the combinational rules with prio = 0.

Verification

- REQ-036: Single read.
  - Stimulus: memory preloaded word 3 = 0xDEADBEEF; m0 read addr 0x0C.
  - Response: m0_req_ready = 1 in cycle T; m0_rsp_valid = 1 with rdata 0xDEADBEEF in T+1; m1_rsp_valid = 0 throughout.
- REQ-037: Contention.
  - Stimulus: after reset, both requesters continuously request reads.
  - Response: grants alternate m0, m1, m0, m1; each rsp_valid follows its grant by exactly 1 cycle with the correct word.
- REQ-038: Write then read.
  - Stimulus: m1 writes 0x12345678 to 0x10; next cycle m0 reads 0x10.
  - Response: mem_write_enable is high for one cycle; m0_rsp_rdata = 0x12345678.
- REQ-039: Range error.
  - Stimulus: ADDR_SIZE = 7; m0 reads 0x100.
  - Response: range_err = 1 from the next cycle; it stays 1 through later legal accesses and clears only on rst.
- REQ-040: Reset mid-read.
  - Stimulus: m1 read accepted; rst asserted asynchronously before the next edge.
  - Response: m1_rsp_valid stays 0; prio = 0; the first post-reset contention grants m0.
- REQ-041: Idle.
  - Stimulus: no valid requests.
  - Response: all mem_* outputs = 0; no ready; prio unchanged.
